// File: rtl/matmul_ctrl.sv
// matmul_ctrl: sequencer for an 8x8 signed matrix multiply, C = A x B.
// Walks the A and B operand RAMs (one-cycle read latency), multiply-
// accumulates each inner product and writes the 19-bit result to C RAM.
// Each element takes 10 cycles: 8 FETCH, 1 DRAIN, 1 WRITE.
module matmul_ctrl #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 19
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [5:0]        a_addr,
    input  logic [DATA_W-1:0] a_data,
    output logic [5:0]        b_addr,
    input  logic [DATA_W-1:0] b_data,
    output logic [5:0]        c_addr,
    output logic [ACC_W-1:0]  c_data,
    output logic              c_wr
);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, WRITE} state_t;

    state_t                    state, state_nx;
    logic [2:0]                i, j, k;
    logic                      v, f;
    logic                      done_r;
    logic signed [ACC_W-1:0]   acc;
    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]   prod_ext;
    logic                      last_elem;

    assign last_elem = (i == 3'd7) && (j == 3'd7);
    assign prod      = $signed(a_data) * $signed(b_data);
    assign prod_ext  = {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};

    // Next-state decode: 8 FETCH cycles, one DRAIN, one WRITE per element.
    always_comb begin
        // NOTE: default first so every path assigns state_nx and no latch is inferred.
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = FETCH;
            FETCH:   if (k == 3'd7) state_nx = DRAIN;
            DRAIN:   state_nx = WRITE;
            WRITE:   state_nx = last_elem ? IDLE : FETCH;
            default: state_nx = IDLE;
        endcase
    end

    // State register, loop counters, pipeline flags and the done pulse.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking so every register samples pre-edge values of the others.
        if (reset) begin
            state  <= IDLE;
            i      <= '0;
            j      <= '0;
            k      <= '0;
            v      <= 1'b0;
            f      <= 1'b0;
            done_r <= 1'b0;
        end else begin
            state  <= state_nx;
            v      <= (state == FETCH);
            f      <= (state == FETCH) && (k == 3'd0);
            done_r <= (state == WRITE) && last_elem;
            case (state)
                IDLE: begin
                    i <= '0;
                    j <= '0;
                    k <= '0;
                end
                FETCH: k <= k + 3'd1;   // wraps 7 -> 0 ready for the next element
                WRITE: begin
                    j <= j + 3'd1;
                    if (j == 3'd7) i <= i + 3'd1;
                end
                default: ;
            endcase
        end
    end

    // Accumulator: data arrives one cycle after its address, flagged by v/f.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc <= '0;
        end else if (v) begin
            acc <= (f ? '0 : acc) + prod_ext;
        end
    end

    // Output decode; addresses are held at zero outside the states that use them.
    always_comb begin
        busy   = (state != IDLE);
        done   = done_r;
        c_wr   = (state == WRITE);
        a_addr = '0;
        b_addr = '0;
        c_addr = '0;
        c_data = '0;
        if (state == FETCH) begin
            a_addr = {i, k};
            b_addr = {k, j};
        end
        if (state == WRITE) begin
            c_addr = {i, j};
            c_data = acc;
        end
    end

endmodule

// File: tb/tb_matmul_ctrl.sv
// tb_matmul_ctrl: behavioural A/B RAMs, a scoreboard of expected C writes
// (address, value, cycle) and table-driven constant-fill runs plus
// hand-written reset and back-to-back sequences.
module tb_matmul_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        busy, done, c_wr;
    logic [5:0]  a_addr, b_addr, c_addr;
    logic [7:0]  a_data, b_data;
    logic [18:0] c_data;

    matmul_ctrl #(.DATA_W(8), .ACC_W(19)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .busy   (busy),
        .done   (done),
        .a_addr (a_addr),
        .a_data (a_data),
        .b_addr (b_addr),
        .b_data (b_data),
        .c_addr (c_addr),
        .c_data (c_data),
        .c_wr   (c_wr)
    );

    always #5 clk = ~clk;

    logic signed [7:0] a_mem [64];
    logic signed [7:0] b_mem [64];
    logic [18:0]       exp_c [64];

    // Synchronous single-port read RAMs with one-cycle latency.
    always @(posedge clk) begin
        a_data <= a_mem[a_addr];
        b_data <= b_mem[b_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    typedef struct {
        logic [5:0]  addr;
        logic [18:0] data;
        int          wcyc;
    } item_t;
    item_t sbq[$];

    // Scoreboard monitor: every write must match the next expected item.
    always @(negedge clk) begin
        item_t it;
        while (sbq.size() > 0 && sbq[0].wcyc < cyc) begin
            it = sbq.pop_front();
            check("missed_write_cycle", 32'(cyc), 32'(it.wcyc));
        end
        if (c_wr) begin
            if (sbq.size() == 0) begin
                check("spurious_write", 32'(c_wr), 32'd0);
            end else begin
                it = sbq.pop_front();
                check("c_addr", 32'(c_addr), 32'(it.addr));
                check("c_data", 32'(c_data), 32'(it.data));
                check("write_cycle", 32'(cyc), 32'(it.wcyc));
            end
        end
    end

    // Expected writes of one run: element e written in cycle base + 10e + 10.
    task automatic push_run(input int base, input int n_elem);
        for (int e = 0; e < n_elem; e++) begin
            item_t it;
            it.addr = 6'(e);
            it.data = exp_c[e];
            it.wcyc = base + 10*e + 10;
            sbq.push_back(it);
        end
    endtask

    function automatic logic [18:0] model(input int n);
        int sum = 0;
        for (int kk = 0; kk < 8; kk++)
            sum += int'(a_mem[(n/8)*8 + kk]) * int'(b_mem[kk*8 + (n%8)]);
        return 19'(sum);
    endfunction

    // Wait (bounded) for done; checks its cycle, busy, and single-cycle width.
    task automatic wait_done(input int exp_cyc, input bit drop_start);
        bit seen = 1'b0;
        for (int n = 0; n < 1500 && !seen; n++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        if (!seen) begin
            check("done_timeout", 32'd0, 32'd1);
        end else begin
            if (drop_start) start = 1'b0;
            check("done_cycle", 32'(cyc), 32'(exp_cyc));
            check("busy_at_done", 32'(busy), 32'd0);
            @(negedge clk);
            check("done_width", 32'(done), 32'd0);
        end
    endtask

    // One full run from IDLE with a single-cycle start pulse.
    task automatic run_once(input string tag);
        int base;
        @(negedge clk);
        base  = cyc;
        push_run(base, 64);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        check({tag, "_busy_c1"}, 32'(busy), 32'd1);
        wait_done(base + 641, 1'b0);
        check({tag, "_queue_empty"}, 32'(sbq.size()), 32'd0);
    endtask

    task automatic fill_random();
        for (int n = 0; n < 64; n++) begin
            a_mem[n] = 8'($urandom);
            b_mem[n] = 8'($urandom);
        end
    endtask

    typedef struct {
        logic signed [7:0] a_val;
        logic signed [7:0] b_val;
        int                exp_val;
    } vec_t;

    initial begin
        vec_t tbl [6];
        int   base;
        int   done_cnt;

        tbl[0] = '{-8'sd128, -8'sd128,  131072};
        tbl[1] = '{-8'sd128,  8'sd127, -130048};
        tbl[2] = '{ 8'sd127,  8'sd127,  129032};
        tbl[3] = '{ 8'sd1,   -8'sd1,        -8};
        tbl[4] = '{-8'sd1,   -8'sd1,         8};
        tbl[5] = '{ 8'sd0,   -8'sd77,        0};

        reset = 1'b1;
        start = 1'b0;
        for (int n = 0; n < 64; n++) begin
            a_mem[n] = '0;
            b_mem[n] = '0;
        end
        repeat (3) @(negedge clk);
        check("rst_busy",   32'(busy),   32'd0);
        check("rst_done",   32'(done),   32'd0);
        check("rst_c_wr",   32'(c_wr),   32'd0);
        check("rst_a_addr", 32'(a_addr), 32'd0);
        check("rst_b_addr", 32'(b_addr), 32'd0);
        check("rst_c_addr", 32'(c_addr), 32'd0);
        check("rst_c_data", 32'(c_data), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Identity A: each result is B sign-extended to 19 bits.
        fill_random();
        for (int n = 0; n < 64; n++) begin
            a_mem[n] = ((n / 8) == (n % 8)) ? 8'sd1 : 8'sd0;
            exp_c[n] = {{11{b_mem[n][7]}}, b_mem[n]};
        end
        run_once("ident");

        // Constant fills: every element equals 8*a*b.
        for (int t = 0; t < 6; t++) begin
            for (int n = 0; n < 64; n++) begin
                a_mem[n] = tbl[t].a_val;
                b_mem[n] = tbl[t].b_val;
                exp_c[n] = 19'(tbl[t].exp_val);
            end
            run_once("const");
        end

        // Random mixed-sign matrices against the reference model.
        for (int r = 0; r < 2; r++) begin
            fill_random();
            for (int n = 0; n < 64; n++) exp_c[n] = model(n);
            run_once("rand");
        end

        // Reset in cycle 300: writes 0..29 complete, then abort with no done.
        fill_random();
        for (int n = 0; n < 64; n++) exp_c[n] = model(n);
        @(negedge clk);
        base  = cyc;
        push_run(base, 30);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int n = 0; n < 400 && cyc < base + 150; n++) @(negedge clk);
        check("abort_busy_mid", 32'(busy), 32'd1);
        for (int n = 0; n < 400 && cyc < base + 300; n++) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_c_wr", 32'(c_wr), 32'd0);
        done_cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        check("abort_no_done", 32'(done_cnt), 32'd0);
        check("abort_queue_empty", 32'(sbq.size()), 32'd0);
        run_once("after_abort");

        // start held high: second run accepted in the done cycle (641).
        fill_random();
        for (int n = 0; n < 64; n++) exp_c[n] = model(n);
        @(negedge clk);
        base  = cyc;
        push_run(base, 64);
        push_run(base + 641, 64);
        start = 1'b1;
        wait_done(base + 641, 1'b0);
        check("held_busy_642", 32'(busy), 32'd1);
        wait_done(base + 1282, 1'b1);
        check("held_queue_empty", 32'(sbq.size()), 32'd0);

        // Reset held with start high: stays idle at reset values.
        @(negedge clk);
        reset = 1'b1;
        start = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("hold_busy",   32'(busy),   32'd0);
            check("hold_done",   32'(done),   32'd0);
            check("hold_c_wr",   32'(c_wr),   32'd0);
            check("hold_addrs",  32'({a_addr, b_addr, c_addr}), 32'd0);
            check("hold_c_data", 32'(c_data), 32'd0);
        end
        start = 1'b0;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("final_idle", 32'(busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/matmul_ctrl.md
# matmul_ctrl

Sequencer for the 8x8 signed matrix multiply datapath, C = A × B. It is the initiator on the synchronous single-port RAM interface: it drives addresses into the A and B operand RAMs, consumes their one-cycle-latency read data, multiply-accumulates, and writes each 19-bit result into the C result RAM. It sits between the top-level start/done control and the three RAM instances.

## Interface
Parameters
- DATA_W, 8, operand width (signed two's complement)
- ACC_W, 19, accumulator/result width; sized so 8 products of −128×−128 cannot overflow

Ports
- clk  in  1  single clock; all state changes on the rising edge
- reset  in  1  synchronous, active-high; returns the block to IDLE
- start  in  1  sampled in IDLE only; starts one full 64-element multiply
- busy  out  1  high from the cycle after start is accepted through the last WRITE cycle
- done  out  1  one-cycle pulse in the first IDLE cycle after the last result write
- a_addr  out  6  A RAM address, row-major, i*8+k
- a_data  in  DATA_W  A RAM read data, valid the cycle after a_addr is presented
- b_addr  out  6  B RAM address, row-major, k*8+j
- b_data  in  DATA_W  B RAM read data, same latency as a_data
- c_addr  out  6  C RAM address, row-major, i*8+j
- c_data  out  ACC_W  signed result; meaningful only while c_wr=1
- c_wr  out  1  C RAM write enable, one cycle per element

## Operation
- Counters: i (row, 0–7), j (col, 0–7), k (inner, 0–7); element order j fastest, then i, i.e. c_addr 0,1,…,63.
- FSM states: IDLE, FETCH, DRAIN, WRITE.
  - IDLE: a_addr=b_addr=c_addr=0, c_wr=0, busy=0. start=1 → FETCH with i=j=k=0.
  - FETCH: present a_addr=i*8+k, b_addr=k*8+j; k increments each cycle. Stay for 8 cycles (k=0..7), then → DRAIN.
  - DRAIN: one cycle; receives the k=7 read data. → WRITE.
  - WRITE: c_wr=1, c_addr=i*8+j, c_data=acc. Then advance j (wrap 7→0 with i+1). If i=7, j=7 → IDLE with done=1; else → FETCH with k=0.
- Accumulate pipeline: valid flag v and first flag f are registered from (state==FETCH) and (k==0). When v=1: acc ← (f ? 0 : acc) + sext(a_data)·sext(b_data). The product is 16-bit signed and the sum is ACC_W signed. acc is not modified when v=0.
- start is ignored while busy=1. start held high continuously causes back-to-back runs, each accepted in its IDLE cycle.
- reset at any time: the next state is IDLE, all counters, acc, v and f are 0, c_wr=0, busy=0, and done=0. No done pulse is issued for an aborted run. C RAM contents already written are left as is.
- Reset values: busy=0, done=0, c_wr=0, a_addr=b_addr=c_addr=0, c_data=0.

## Timing
- Call the edge that accepts start E0, and the cycle after it cycle 1.
- Element e (0–63) occupies cycles 10e+1 … 10e+10: 8 FETCH, 1 DRAIN, 1 WRITE. c_wr is high exactly in cycle 10e+10.
- The last write is in cycle 640. done=1 and busy=0 in cycle 641, which is an IDLE cycle, and start is accepted in that same cycle.
- Read latency is exactly one cycle. Data for an address presented in cycle t is consumed at the end of cycle t+1.
- Total runtime is 640 cycles per matrix, with 64 write pulses and no gaps other than FETCH/DRAIN.

## Test plan
- A = identity, B = random signed values → C[n] = sext19(B[n]) for all 64 n; c_wr high exactly in cycles 10, 20, …, 640; done in cycle 641.
- A = B = all −128 → every C = +131072 (0x20000); A all −128, B all +127 → every C = −130048. This covers the width and sign-extension corners.
- Random A and B against a reference model, including mixed signs → all 64 results match; c_addr sequence is 0..63 in order.
- Assert reset in cycle 300 → c_wr=0 and busy=0 from the next cycle, with no done pulse. Then start again → a full correct result with the original timing.
- start held high throughout → start pulses during busy are ignored; a second run begins at the done cycle (641) and its first write lands in cycle 651.
- Reset held with start high → the block stays in IDLE with all outputs at reset values.
